// File: rtl/stream_burst_src.sv
// Burst stream source: emits burst_len beats of an incrementing pattern (or an LFSR
// pattern when STREAM_BURST_SRC_LFSR_EN is defined) with an optional gap after each beat.
module stream_burst_src #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int GAP_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS = 8'hB8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic [GAP_WIDTH-1:0]  gap,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  beats_sent,
  output logic [15:0]           stall_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]            state;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [GAP_WIDTH-1:0]  gap_q;
  logic [GAP_WIDTH-1:0]  gap_cnt;
  logic [DATA_WIDTH-1:0] next_data;
  logic [DATA_WIDTH-1:0] first_data;
  logic                  handshake;
  logic                  final_beat;

`ifdef STREAM_BURST_SRC_LFSR_EN
  // An all-zero LFSR state would lock up, so a zero seed starts at 1.
  assign next_data  = {m_data[DATA_WIDTH-2:0], ^(m_data & LFSR_TAPS)};
  assign first_data = (seed == '0) ? DATA_WIDTH'(1) : seed;
`else
  logic unused_taps;
  assign unused_taps = ^LFSR_TAPS;
  assign next_data   = m_data + DATA_WIDTH'(1);
  assign first_data  = seed;
`endif

  // Stream handshake: a beat transfers at a rising edge where m_valid and m_ready are both 1;
  // m_valid/m_data never change while m_valid=1 and m_ready=0 unless abort or rst.
  assign handshake  = m_valid & m_ready;
  assign final_beat = (beats_sent + LEN_WIDTH'(1)) == len_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      m_valid    <= 1'b0;
      m_data     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      beats_sent <= '0;
      stall_cnt  <= '0;
      len_q      <= '0;
      gap_q      <= '0;
      gap_cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (handshake) begin
        beats_sent <= beats_sent + LEN_WIDTH'(1);
        m_data     <= next_data;
      end
      if (m_valid && !m_ready && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;

      case (state)
        IDLE: begin
          if (start && !abort) begin
            if (burst_len != '0) begin
              state      <= SEND;
              len_q      <= burst_len;
              gap_q      <= gap;
              m_data     <= first_data;
              m_valid    <= 1'b1;
              busy       <= 1'b1;
              beats_sent <= '0;
              stall_cnt  <= '0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        SEND: begin
          if (abort) begin
            state   <= IDLE;
            m_valid <= 1'b0;
            busy    <= 1'b0;
          end else if (handshake) begin
            if (final_beat) begin
              state   <= IDLE;
              m_valid <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else if (gap_q != '0) begin
              state   <= GAP;
              m_valid <= 1'b0;
              gap_cnt <= gap_q;
            end
          end
        end
        GAP: begin
          if (abort) begin
            state   <= IDLE;
            m_valid <= 1'b0;
            busy    <= 1'b0;
          end else if (gap_cnt == GAP_WIDTH'(1)) begin
            state   <= SEND;
            m_valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GAP_WIDTH'(1);
          end
        end
        default: begin
          state   <= IDLE;
          m_valid <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_burst_src.sv
// Testbench for stream_burst_src: random and directed bursts checked by a scoreboard
// fed from a behavioural model of the beat sequence, gaps, done and counters.
module tb_stream_burst_src;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  burst_len = '0;
  logic [3:0]  gap = '0;
  logic [7:0]  seed = '0;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready = 1'b0;
  logic        busy;
  logic        done;
  logic [7:0]  beats_sent;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  int stall_model = 0;
  logic [7:0] exp_q[$];
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data = '0;

  stream_burst_src dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .burst_len(burst_len), .gap(gap), .seed(seed),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .busy(busy), .done(done), .beats_sent(beats_sent), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected beat sequence for one burst, straight from the pattern rule.
  task automatic push_expected(input int len, input logic [7:0] sd);
    logic [7:0] cur;
    logic [7:0] t;
`ifdef STREAM_BURST_SRC_LFSR_EN
    cur = (sd == 8'h00) ? 8'h01 : sd;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(cur);
      t = cur & 8'hB8;
      cur = {cur[6:0], ^t};
    end
`else
    for (int i = 0; i < len; i++) begin
      cur = 8'((int'(sd) + i) % 256);
      exp_q.push_back(cur);
    end
`endif
  endtask

  // Monitor: pops an expected beat on every handshake and checks the hold rule while stalled.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", 32'(m_data), 32'(hold_data));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected: got %0h, expected no beat", m_data);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 32'(m_data), 32'(e));
        end
      end
      if (m_valid && !m_ready) stall_model++;
      hold_pend = m_valid && !m_ready && !abort;
      hold_data = m_data;
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_data"}, 32'(m_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_beats"}, 32'(beats_sent), 32'd0);
    check({tag, "_stall"}, 32'(stall_cnt), 32'd0);
  endtask

  task automatic run_burst(input int len, input int g, input logic [7:0] sd, input int pct,
                           input int stall_first, input int abort_at, input bit spam);
    int hs = 0;
    int zeros = 0;
    int cycles = 0;
    bit counting = 0;
    bit finished = 0;
    logic [7:0] first;
    @(posedge clk); #1;
    start = 1'b1; burst_len = 8'(len); gap = 4'(g); seed = sd;
    push_expected(len, sd);
    first = exp_q[0];
    stall_model = 0;
    @(posedge clk); #1;
    start = 1'b0;
    while (!finished && cycles < 2000) begin
      m_ready = (cycles < stall_first) ? 1'b0 : (int'($urandom_range(0, 99)) < pct);
      abort = (abort_at != 0 && hs == abort_at);
      if (spam && !abort) begin
        start = 1'($urandom_range(0, 1));
        burst_len = 8'($urandom_range(0, 255));
        gap = 4'($urandom_range(0, 15));
        seed = 8'($urandom_range(0, 255));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (cycles == 0) begin
        check("first_valid", 32'(m_valid), 32'd1);
        check("first_data", 32'(m_data), 32'(first));
        check("first_busy", 32'(busy), 32'd1);
        check("first_beats", 32'(beats_sent), 32'd0);
        check("first_stall", 32'(stall_cnt), 32'd0);
      end
      if (counting) begin
        if (!m_valid) zeros++;
        else begin
          check("gap_len", 32'(zeros), 32'(g));
          counting = 0;
        end
      end
      if (abort) begin
        if (m_valid && m_ready) hs++;
        @(posedge clk); #1;
        abort = 1'b0; m_ready = 1'b0; start = 1'b0;
        @(negedge clk);
        check("abort_valid", 32'(m_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_beats", 32'(beats_sent), 32'(hs));
        check("abort_stall", 32'(stall_cnt), 32'(stall_model));
        exp_q.delete();
        finished = 1;
      end else if (m_valid && m_ready) begin
        hs++;
        if (hs == len) begin
          @(posedge clk); #1;
          m_ready = 1'b0; start = 1'b0;
          @(negedge clk);
          check("end_done", 32'(done), 32'd1);
          check("end_valid", 32'(m_valid), 32'd0);
          check("end_busy", 32'(busy), 32'd0);
          check("end_beats", 32'(beats_sent), 32'(len));
          check("end_stall", 32'(stall_cnt), 32'(stall_model));
          check("end_queue_empty", 32'(exp_q.size()), 32'd0);
          if (pct == 100) check("stall_exact", 32'(stall_cnt), 32'(stall_first));
          @(posedge clk); #1;
          @(negedge clk);
          check("done_one_cycle", 32'(done), 32'd0);
          finished = 1;
        end else begin
          counting = 1;
          zeros = 0;
          @(posedge clk); #1;
        end
      end else begin
        @(posedge clk); #1;
      end
      cycles++;
    end
    if (!finished) begin
      check("burst_timeout", 32'(cycles), 32'd0);
      exp_q.delete();
    end
    start = 1'b0; abort = 1'b0; m_ready = 1'b0;
  endtask

  task automatic zero_len_burst();
    @(posedge clk); #1;
    start = 1'b1; burst_len = 8'd0; gap = 4'd3; seed = 8'h77;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero_done", 32'(done), 32'd1);
    check("zero_valid", 32'(m_valid), 32'd0);
    check("zero_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("zero_done_clear", 32'(done), 32'd0);
    check("zero_valid_after", 32'(m_valid), 32'd0);
  endtask

  task automatic reset_mid_burst();
    @(posedge clk); #1;
    start = 1'b1; burst_len = 8'd10; gap = 4'd0; seed = 8'($urandom_range(0, 255));
    push_expected(10, seed);
    @(posedge clk); #1;
    start = 1'b0; m_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len, g, pct, ab;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    run_burst(4, 0, 8'h10, 100, 0, 0, 0);
    run_burst(3, 2, 8'hFE, 100, 0, 0, 0);
    run_burst(2, 0, 8'h5A, 100, 5, 0, 0);
    run_burst(10, 2, 8'h33, 100, 0, 3, 1);
    zero_len_burst();
    run_burst(3, 0, 8'h00, 100, 0, 0, 0);
    reset_mid_burst();
    run_burst(2, 1, 8'hC3, 100, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      len = $urandom_range(1, 7);
      g   = $urandom_range(0, 3);
      pct = $urandom_range(40, 100);
      ab  = (len > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, len - 1)) : 0;
      run_burst(len, g, 8'($urandom_range(0, 255)), pct, $urandom_range(0, 2), ab,
                1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_burst_src.md
STREAM_BURST_SRC -- requirements
Module: stream_burst_src

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, stream data width.
REQ-002 SHALL have parameter LEN_WIDTH, default 8, width of the burst length and beat counter.
REQ-003 SHALL have parameter GAP_WIDTH, default 4, width of the inter-beat gap field.
REQ-004 SHALL have parameter LFSR_TAPS, default 8'hB8, LFSR feedback mask of DATA_WIDTH bits.
REQ-005 SHALL have port clk  input  1  single clock, all logic on posedge.
REQ-006 SHALL have port rst  input  1  reset: one clock; reset is synchronous and active-high.
REQ-007 SHALL have port start  input  1  burst request, sampled only in IDLE.
REQ-008 SHALL have port abort  input  1  terminate the current burst.
REQ-009 SHALL have port burst_len  input  LEN_WIDTH  beats per burst, latched on start.
REQ-010 SHALL have port gap  input  GAP_WIDTH  idle cycles after each non-final accepted beat, latched on start.
REQ-011 SHALL have port seed  input  DATA_WIDTH  first data value, latched on start.
REQ-012 SHALL have port m_valid  output  1  beat valid.
REQ-013 SHALL have port m_data  output  DATA_WIDTH  beat data.
REQ-014 SHALL have port m_ready  input  1  sink ready.
REQ-015 SHALL have port busy  output  1  burst in progress.
REQ-016 SHALL have port done  output  1  one-cycle pulse on normal burst completion.
REQ-017 SHALL have port beats_sent  output  LEN_WIDTH  accepted beats in the current or last burst.
REQ-018 SHALL have port stall_cnt  output  16  saturating count of cycles with m_valid=1 and m_ready=0.

Function
REQ-019 SHALL implement states IDLE, SEND and GAP; all outputs registered.
REQ-020 SHALL, in IDLE with start=1 and burst_len>0, latch burst_len, gap and seed, clear beats_sent and stall_cnt, and enter SEND next cycle with m_valid=1, m_data=seed, busy=1.
REQ-021 SHALL, on start=1 with burst_len=0, stay IDLE and pulse done the next cycle, with no beat issued.
REQ-022 SHALL define a handshake as m_valid=1 and m_ready=1 at a rising edge; each handshake increments beats_sent.
REQ-023 SHALL hold m_valid and m_data stable while m_valid=1 and m_ready=0.
REQ-024 SHALL increment stall_cnt on every m_valid=1 and m_ready=0 cycle, saturating at 16'hFFFF.
REQ-025 SHALL advance m_data to the next pattern value after each handshake; the default pattern is seed+1, wrapping modulo 2^DATA_WIDTH.
REQ-026 SHALL, after a non-final handshake with latched gap=G>0, enter GAP with m_valid=0 for exactly G cycles, then return to SEND.
REQ-027 SHALL, after a non-final handshake with gap=0, stay in SEND with m_valid=1 (back-to-back beats).
REQ-028 SHALL, on the final handshake (beats_sent reaches the latched burst_len), go to IDLE with m_valid=0, busy=0 and done=1 for exactly one cycle.
REQ-029 SHALL, on abort=1 in SEND or GAP, go to IDLE next cycle with m_valid=0, busy=0 and no done pulse; beats_sent keeps the count of completed handshakes, including one in the abort cycle.
REQ-030 SHALL ignore start while busy=1; abort in IDLE has no effect; abort takes priority over start.
REQ-031 SHALL allow start in the cycle done is high, beginning a new burst.

Reset
REQ-032 SHALL, on rst=1 at a clock edge, set state=IDLE, m_valid=0, m_data=0, busy=0, done=0, beats_sent=0 and stall_cnt=0, with every latched field cleared.
REQ-033 SHALL, on reset mid-burst, drop m_valid the next cycle without a done pulse; reset overrides start and abort.

Configuration
REQ-034 SHALL, with macro STREAM_BURST_SRC_LFSR_EN defined, generate the pattern as next = {cur[DATA_WIDTH-2:0], ^(cur & LFSR_TAPS)}, and substitute a latched seed of 0 with 1.
REQ-035 SHALL, without STREAM_BURST_SRC_LFSR_EN, use the incrementing pattern and exclude all LFSR logic.

Verification
REQ-036 SHALL cover: burst_len=4, gap=0, seed=8'h10, m_ready=1 -> data 10,11,12,13 on consecutive cycles, done one cycle after 13, beats_sent=4.
REQ-037 SHALL cover: burst_len=3, gap=2, seed=8'hFE -> data FE, FF, 00 with two m_valid=0 cycles between beats (wrap checked).
REQ-038 SHALL cover: burst_len=2, m_ready low for 5 cycles on the first beat -> m_data held at seed, stall_cnt=5, both beats delivered.
REQ-039 SHALL cover: burst_len=10, abort after third handshake -> m_valid=0 next cycle, no done, beats_sent=3; a second start is ignored while busy.
REQ-040 SHALL cover: LFSR_EN build, seed=0, burst_len=3 -> data 01, 02, 04; burst_len=0 -> done pulse only.
REQ-041 SHALL cover: rst asserted mid-burst -> all outputs at reset values the next cycle.
